// File: rtl/array_loader.sv
// array_loader
//
// Upstream stage for the balanced array adder. Bytes arrive over a
// valid/ready handshake and fill a DEPTH-entry array. A complete frame is then
// offered to the adder with a valid/ack handshake. The array stays stable until
// the adder acknowledges the frame. A sequential running sum of the frame is
// kept alongside the array so the tree-adder result can be cross-checked.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous reset, active-high
//   in_valid     in   in_data holds a byte
//   in_data      in   signed byte
//   in_ready     out  a byte can be accepted this cycle (high in FILL)
//   flush        in   discard the partially filled frame (ignored in HOLD)
//   array        out  frame contents, one signed byte per entry
//   frame_valid  out  array holds a complete, stable frame
//   frame_ack    in   consumer has taken the frame (sampled in HOLD only)
//   fill_count   out  bytes accepted in the current frame
//   frame_sum    out  signed running sum of the accepted bytes

module array_loader #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [7:0]       in_data,
    output logic                    in_ready,
    input  logic                    flush,
    output logic signed [7:0]       array [0:DEPTH-1],
    output logic                    frame_valid,
    input  logic                    frame_ack,
    output logic [CNT_W-1:0]        fill_count,
    output logic signed [31:0]      frame_sum
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LastPtr = PTR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        StFill,
        StHold
    } state_e;

    state_e           state;
    logic [PTR_W-1:0] wr_ptr;

    // Ready depends on state alone, so it reads 1 straight out of reset.
    assign in_ready = (state == StFill);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= StFill;
            wr_ptr      <= '0;
            fill_count  <= '0;
            frame_sum   <= '0;
            frame_valid <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                array[i] <= '0;
            end
        end else begin
            case (state)
                StFill: begin
                    // Flush beats a simultaneous accept: the byte is dropped.
                    // Array contents stay; stale entries are overwritten later.
                    if (flush) begin
                        wr_ptr     <= '0;
                        fill_count <= '0;
                        frame_sum  <= '0;
                    end else if (in_valid) begin
                        array[wr_ptr] <= in_data;
                        fill_count    <= fill_count + CNT_W'(1);
                        frame_sum     <= frame_sum + {{24{in_data[7]}}, in_data};
                        if (wr_ptr == LastPtr) begin
                            // Pointer wraps so it never exceeds DEPTH-1.
                            wr_ptr      <= '0;
                            state       <= StHold;
                            frame_valid <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + PTR_W'(1);
                        end
                    end
                end

                StHold: begin
                    // Count and sum stay frozen for the consumer until the ack.
                    if (frame_ack) begin
                        state       <= StFill;
                        frame_valid <= 1'b0;
                        wr_ptr      <= '0;
                        fill_count  <= '0;
                        frame_sum   <= '0;
                    end
                end

                default: begin
                    state <= StFill;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_loader.sv
module tb_array_loader;

    localparam int DEPTH = 64;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic signed [7:0]      in_data;
    logic                   in_ready;
    logic                   flush;
    logic signed [7:0]      array [0:DEPTH-1];
    logic                   frame_valid;
    logic                   frame_ack;
    logic [CNT_W-1:0]       fill_count;
    logic signed [31:0]     frame_sum;

    array_loader #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .flush       (flush),
        .array       (array),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .fill_count  (fill_count),
        .frame_sum   (frame_sum)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: bytes of the frame in flight, array image, sum, pointer.
    logic signed [7:0] exp_q [$];
    logic signed [7:0] exp_img [DEPTH];
    int                mptr;
    int                msum;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear();
        mptr = 0;
        msum = 0;
        exp_q.delete();
    endtask

    // Drive one byte for one edge; the caller guarantees the loader is in FILL.
    task automatic send(input logic signed [7:0] v);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        exp_q.push_back(v);
        exp_img[mptr] = v;
        mptr++;
        msum += int'(v);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, ":valid"}, 32'(frame_valid), 1);
        chk({tag, ":ready"}, 32'(in_ready), 0);
        chk({tag, ":count"}, 32'(fill_count), DEPTH);
        chk({tag, ":sum"}, frame_sum, msum);
        for (int i = 0; i < DEPTH; i++) begin
            if (exp_q.size() > 0) begin
                chk($sformatf("%s:arr%0d", tag, i), 32'(array[i]), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic ack_frame(input string tag);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk({tag, ":ack_valid"}, 32'(frame_valid), 0);
        chk({tag, ":ack_count"}, 32'(fill_count), 0);
        chk({tag, ":ack_sum"}, frame_sum, 0);
        chk({tag, ":ack_ready"}, 32'(in_ready), 1);
        model_clear();
    endtask

    int nz;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        frame_ack = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_img[i] = '0;
        model_clear();

        // Reset state, checked before any clock edge.
        #2;
        chk("rst:ready", 32'(in_ready), 1);
        chk("rst:valid", 32'(frame_valid), 0);
        chk("rst:count", 32'(fill_count), 0);
        chk("rst:sum", frame_sum, 0);
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (array[i] !== 8'sd0) nz++;
        chk("rst:array_nonzero", nz, 0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        // 1: 0..63 back to back.
        for (int i = 0; i < DEPTH - 1; i++) send(8'(i));
        chk("t1:valid_early", 32'(frame_valid), 0);
        chk("t1:count63", 32'(fill_count), DEPTH - 1);
        send(8'(DEPTH - 1));
        chk("t1:sum_2016", frame_sum, 2016);
        check_frame("t1");

        // 2: byte held off during HOLD, then accepted after the ack.
        in_valid = 1'b1;
        in_data  = 8'sh55;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("t2:ready%0d", c), 32'(in_ready), 0);
            chk($sformatf("t2:count%0d", c), 32'(fill_count), DEPTH);
            chk($sformatf("t2:arr0_%0d", c), 32'(array[0]), 0);
        end
        ack_frame("t2");
        send(8'sh55);
        in_valid = 1'b0;
        chk("t2:arr0", 32'(array[0]), 32'(exp_img[0]));
        chk("t2:count1", 32'(fill_count), 1);
        chk("t2:sum", frame_sum, msum);

        // Flush without data clears the count but keeps the array.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        model_clear();
        chk("t2f:count", 32'(fill_count), 0);
        chk("t2f:sum", frame_sum, 0);
        chk("t2f:arr0_kept", 32'(array[0]), 32'(exp_img[0]));

        // 3: all 0xFF; flush in HOLD ignored; flush+ack honours the ack.
        for (int i = 0; i < DEPTH; i++) send(8'shFF);
        in_valid = 1'b0;
        chk("t3:sum_m64", frame_sum, -64);
        check_frame("t3");
        flush = 1'b1;
        tick();
        chk("t3:hold_flush_valid", 32'(frame_valid), 1);
        chk("t3:hold_flush_count", 32'(fill_count), DEPTH);
        chk("t3:hold_flush_sum", frame_sum, -64);
        ack_frame("t3");
        flush = 1'b0;

        // 4: 10 bytes, then flush with a valid 0x7F that must be dropped.
        for (int i = 0; i < 10; i++) send(8'(100 + i));
        chk("t4:count10", 32'(fill_count), 10);
        in_valid = 1'b1;
        in_data  = 8'sh7F;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        model_clear();
        chk("t4:count", 32'(fill_count), 0);
        chk("t4:sum", frame_sum, 0);
        chk("t4:arr10_not7f", 32'(array[10]), 32'(exp_img[10]));
        chk("t4:arr0_kept", 32'(array[0]), 32'(exp_img[0]));
        for (int i = 0; i < DEPTH; i++) send(8'(i * 3 - 90));
        in_valid = 1'b0;
        check_frame("t4");
        ack_frame("t4");

        // 5: async reset mid-clock after 30 bytes.
        for (int i = 0; i < 30; i++) send(8'(i + 1));
        in_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk("t5:count", 32'(fill_count), 0);
        chk("t5:sum", frame_sum, 0);
        chk("t5:valid", 32'(frame_valid), 0);
        chk("t5:ready", 32'(in_ready), 1);
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (array[i] !== 8'sd0) nz++;
        chk("t5:array_nonzero", nz, 0);
        #2;
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_img[i] = '0;
        model_clear();
        tick();

        // 6: three frames of 0..63 with random gaps and delayed acks.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < DEPTH; i++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    tick();
                end
                send(8'(i));
            end
            in_valid = 1'b0;
            chk($sformatf("t6f%0d:sum_2016", f), frame_sum, 2016);
            check_frame($sformatf("t6f%0d", f));
            begin
                int dly;
                dly = $urandom_range(0, 7);
                for (int d = 0; d < dly; d++) begin
                    tick();
                    chk($sformatf("t6f%0d:hold%0d", f, d), 32'(frame_valid), 1);
                end
            end
            ack_frame($sformatf("t6f%0d", f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
